// File: rtl/cam_tag_reader.sv
// cam_tag_reader
//   Snapshots the CAM match vector on start, then walks the set bits from the
//   lowest index upward. For each set bit it reads the CAM word at that index
//   and offers the {index, word} pair on a valid/ready output. When the bits
//   run out, or on abort, it pulses done and reports how many pairs were
//   accepted.
//
// Parameters
//   CELL_QUANT  number of CAM cells (width of the tag vector)
//   WORD_SIZE   CAM word width
//   ADDR_W      derived: clogb2(CELL_QUANT), wide enough to hold CELL_QUANT
//
// Ports
//   CLK100MHZ    in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   start        in   snapshot tags and begin a scan (honoured only when idle)
//   abort        in   cancel the scan in progress
//   tags         in   [CELL_QUANT] match vector from the CAM
//   cam_doutb    in   [WORD_SIZE] CAM asynchronous read data for rd_addr
//   rd_addr      out  [ADDR_W] CAM read address (0 outside SCAN)
//   out_valid    out  out_addr/out_data pair valid
//   out_ready    in   consumer accepts the pair
//   out_addr     out  [ADDR_W] index of the matched cell
//   out_data     out  [WORD_SIZE] word read from that cell
//   busy         out  scan in progress (state not IDLE)
//   done         out  one-cycle pulse at scan end
//   match_count  out  [ADDR_W] pairs accepted in the last scan

package cam_tag_reader_pkg;
  // Number of shifts needed to empty the value: 512 -> 10.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction
endpackage

module cam_tag_reader
  import cam_tag_reader_pkg::*;
#(
  parameter  int CELL_QUANT = 512,
  parameter  int WORD_SIZE  = 8,
  localparam int ADDR_W     = clogb2(CELL_QUANT)
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CELL_QUANT-1:0] tags,
  input  logic [WORD_SIZE-1:0]  cam_doutb,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [WORD_SIZE-1:0]  out_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     match_count
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t                  state, state_nx;
  logic [CELL_QUANT-1:0]   snap, snap_nx;
  logic [CELL_QUANT-1:0]   low_bit;
  logic [ADDR_W-1:0]       idx;
  logic [ADDR_W-1:0]       cnt, cnt_nx;
  logic                    out_valid_nx;
  logic [ADDR_W-1:0]       out_addr_nx;
  logic [WORD_SIZE-1:0]    out_data_nx;
  logic [ADDR_W-1:0]       match_count_nx;
  logic                    snap_empty;

  // Priority encoder: descending loop so the lowest set index is written last.
  always_comb begin
    idx = '0;
    for (int i = CELL_QUANT - 1; i >= 0; i--) begin
      if (snap[i]) idx = i[ADDR_W-1:0];
    end
  end

  // One-hot of the lowest set bit (x & -x), used to retire that bit without
  // an index-width-dependent part select.
  assign low_bit    = snap & (~snap + CELL_QUANT'(1));
  assign snap_empty = (snap == '0);

  always_comb begin
    state_nx       = state;
    snap_nx        = snap;
    cnt_nx         = cnt;
    out_valid_nx   = out_valid;
    out_addr_nx    = out_addr;
    out_data_nx    = out_data;
    match_count_nx = match_count;
    rd_addr        = '0;

    case (state)
      IDLE: begin
        if (start) begin
          snap_nx  = tags;
          cnt_nx   = '0;
          state_nx = SCAN;
        end
      end

      SCAN: begin
        rd_addr = idx;
        if (abort) begin
          snap_nx      = '0;
          out_valid_nx = 1'b0;
          state_nx     = DONE;
        end else if (snap_empty) begin
          state_nx = DONE;
        end else begin
          out_addr_nx  = idx;
          out_data_nx  = cam_doutb;
          out_valid_nx = 1'b1;
          snap_nx      = snap & ~low_bit;
          state_nx     = EMIT;
        end
      end

      EMIT: begin
        if (out_valid && out_ready) begin
          cnt_nx       = cnt + ADDR_W'(1);
          out_valid_nx = 1'b0;
          // With nothing left to emit, skip the empty SCAN pass and finish
          // straight away; the scan ends one cycle after the last handshake.
          state_nx     = snap_empty ? DONE : SCAN;
        end
        // A handshake in the abort cycle is still counted above.
        if (abort) begin
          out_valid_nx = 1'b0;
          snap_nx      = '0;
          state_nx     = DONE;
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // DONE is only ever entered for one cycle, so loading here makes the
    // count valid alongside the done pulse and held until the next scan ends.
    if (state_nx == DONE) match_count_nx = cnt_nx;
  end

  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      snap        <= '0;
      cnt         <= '0;
      match_count <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
    end else begin
      state       <= state_nx;
      snap        <= snap_nx;
      cnt         <= cnt_nx;
      match_count <= match_count_nx;
      out_valid   <= out_valid_nx;
      out_addr    <= out_addr_nx;
      out_data    <= out_data_nx;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_cam_tag_reader.sv
// Testbench for cam_tag_reader: table of scan vectors (fixed corner cases plus
// randomised tags/ready/abort) checked against a scoreboard built from the tag
// set, plus hand-written reset and idle-abort sequences.
module tb_cam_tag_reader;
  localparam int CQ = 512;
  localparam int WS = 8;
  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [CQ-1:0] tags;
  logic [WS-1:0] cam_doutb;
  logic [AW-1:0] rd_addr;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [WS-1:0] out_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] match_count;

  logic [WS-1:0] cam_mem [CQ];

  int errors;
  int checks;

  cam_tag_reader #(.CELL_QUANT(CQ), .WORD_SIZE(WS)) dut (
    .CLK100MHZ  (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .tags       (tags),
    .cam_doutb  (cam_doutb),
    .rd_addr    (rd_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .match_count(match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous CAM read port model.
  assign cam_doutb = cam_mem[rd_addr[8:0]];

  typedef struct {
    logic [CQ-1:0] tags;
    int            ready_pct;  // chance (percent) that out_ready is high
    int            hold;       // out_ready forced low until cycle 2+hold
    int            abort_n;    // abort while pair abort_n handshakes; -1 none
    int            exp_count;
    int            exp_done;   // expected done cycle; -1 when not fixed
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_scan(input vec_t v, input int vnum);
    int            exp_q[$];
    int            cyc;
    int            accepted;
    int            first_cyc;
    int            done_cyc;
    int            budget;
    int            exp_a;
    bit            was_held;
    logic [AW-1:0] held_a;
    logic [WS-1:0] held_d;

    for (int i = 0; i < CQ; i++) if (v.tags[i]) exp_q.push_back(i);
    accepted  = 0;
    first_cyc = -1;
    done_cyc  = -1;
    was_held  = 1'b0;
    held_a    = '0;
    held_d    = '0;
    budget    = 2 * CQ + v.hold + 2000;

    @(posedge clk); #1;
    start = 1'b1; tags = v.tags; out_ready = 1'b0; abort = 1'b0;
    @(posedge clk); #1;   // start edge is cycle 1
    start = 1'b0;
    cyc = 1;
    forever begin
      // Tags keep changing; only the snapshot may matter.
      for (int k = 0; k < CQ / 32; k++) tags[k*32 +: 32] = $urandom;
      if (was_held) begin
        chk($sformatf("v%0d hold_valid c%0d", vnum, cyc), 64'(out_valid), 64'(1));
        chk($sformatf("v%0d hold_addr c%0d", vnum, cyc), 64'(out_addr), 64'(held_a));
        chk($sformatf("v%0d hold_data c%0d", vnum, cyc), 64'(out_data), 64'(held_d));
      end
      out_ready = (cyc >= 2 + v.hold) && ($urandom_range(99) < v.ready_pct);
      abort = 1'b0;
      start = 1'b0;
      if (out_valid) begin
        start = 1'($urandom_range(1));  // must be ignored mid-scan
        chk($sformatf("v%0d rd_addr_emit c%0d", vnum, cyc), 64'(rd_addr), 64'(0));
        if (first_cyc < 0) first_cyc = cyc;
        if (out_ready && (accepted + 1 == v.abort_n)) abort = 1'b1;
      end
      #4;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL v%0d extra_pair: got addr %0d, expected no more pairs", vnum, out_addr);
        end else begin
          exp_a = exp_q.pop_front();
          chk($sformatf("v%0d pair%0d_addr", vnum, accepted), 64'(out_addr), 64'(exp_a));
          chk($sformatf("v%0d pair%0d_data", vnum, accepted), 64'(out_data), 64'(cam_mem[exp_a]));
        end
        accepted++;
      end
      was_held = out_valid && !out_ready;
      held_a   = out_addr;
      held_d   = out_data;
      if (done) begin
        done_cyc = cyc;
        chk($sformatf("v%0d match_count_at_done", vnum), 64'(match_count), 64'(v.exp_count));
        break;
      end
      if (cyc > budget) begin
        errors++; checks++;
        $display("FAIL v%0d timeout: got no done after %0d cycles, expected done", vnum, cyc);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("v%0d done_one_cycle", vnum), 64'(done), 64'(0));
    chk($sformatf("v%0d busy_after", vnum), 64'(busy), 64'(0));
    chk($sformatf("v%0d match_count_hold", vnum), 64'(match_count), 64'(v.exp_count));
    chk($sformatf("v%0d accepted", vnum), 64'(accepted), 64'(v.exp_count));
    if (v.exp_done >= 0)
      chk($sformatf("v%0d done_cycle", vnum), 64'(done_cyc), 64'(v.exp_done));
    if (v.ready_pct == 100 && v.hold == 0 && v.exp_count > 0)
      chk($sformatf("v%0d first_valid_cycle", vnum), 64'(first_cyc), 64'(2));
  endtask

  function automatic vec_t mk(input logic [CQ-1:0] t, input int pct, input int hold,
                              input int ab, input int cnt, input int dcyc);
    vec_t v;
    v.tags = t; v.ready_pct = pct; v.hold = hold;
    v.abort_n = ab; v.exp_count = cnt; v.exp_done = dcyc;
    return v;
  endfunction

  initial begin
    logic [CQ-1:0] t;
    int            n;
    int            ab;

    errors = 0; checks = 0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; tags = '0;
    for (int i = 0; i < CQ; i++) cam_mem[i] = WS'($urandom);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_match_count", 64'(match_count), 64'(0));
    chk("rst_out_addr", 64'(out_addr), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_rd_addr", 64'(rd_addr), 64'(0));
    rst = 1'b1;

    // ---- abort while idle does nothing ----
    abort = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("idle_abort_busy", 64'(busy), 64'(0));
      chk("idle_abort_done", 64'(done), 64'(0));
    end
    abort = 1'b0;

    // ---- vector table ----
    t = '0; t[0] = 1'b1; t[3] = 1'b1; t[5] = 1'b1;
    vecs.push_back(mk(t, 100, 0, -1, 3, 7));
    vecs.push_back(mk('0, 100, 0, -1, 0, 2));
    t = '0; t[1] = 1'b1; t[2] = 1'b1;
    vecs.push_back(mk(t, 100, 5, -1, 2, 10));
    vecs.push_back(mk('1, 100, 0, -1, 512, 1025));
    t = '0; t[2] = 1'b1; t[9] = 1'b1; t[10] = 1'b1; t[300] = 1'b1;
    vecs.push_back(mk(t, 100, 0, 2, 2, 5));
    t = '0; t[CQ-1] = 1'b1;
    vecs.push_back(mk(t, 100, 0, -1, 1, 3));
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < CQ; i++) t[i] = ($urandom_range(15) == 0);
      n  = $countones(t);
      ab = -1;
      if (r >= 4 && n > 0) ab = int'($urandom_range(n - 1)) + 1;
      vecs.push_back(mk(t, int'($urandom_range(100, 30)), 0, ab,
                        (ab >= 0) ? ab : n, -1));
    end

    foreach (vecs[i]) run_scan(vecs[i], i);

    // ---- reset while EMIT holds out_valid ----
    t = '0; t[4] = 1'b1; t[7] = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; tags = t; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;   // cycle 2: pair held
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    chk("pre_rst_addr", 64'(out_addr), 64'(4));
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_done", 64'(done), 64'(0));
    chk("async_rst_match_count", 64'(match_count), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("post_rst_no_done", 64'(done), 64'(0));
      chk("post_rst_idle", 64'(busy), 64'(0));
    end
    t = '0; t[0] = 1'b1; t[3] = 1'b1; t[5] = 1'b1;
    run_scan(mk(t, 100, 0, -1, 3, 7), 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_tag_reader.md
CAM_TAG_READER -- requirements
Module: cam_tag_reader

Interface
REQ-001 SHALL have parameter CELL_QUANT, default 512, meaning the number of CAM cells (the width of the tag vector).
REQ-002 SHALL have parameter WORD_SIZE, default 8, meaning the CAM word width.
REQ-003 SHALL define ADDR_W = clogb2(CELL_QUANT), using the CAM's loop-shift clogb2 (512 -> 10).
REQ-004 SHALL have port CLK100MHZ, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, meaning a request to snapshot tags and begin a scan.
REQ-007 SHALL have port abort, input, 1, meaning a synchronous cancel of the scan in progress.
REQ-008 SHALL have port tags, input, CELL_QUANT, meaning the match vector from the CAM.
REQ-009 SHALL have port cam_doutb, input, WORD_SIZE, meaning the CAM asynchronous read data for rd_addr.
REQ-010 SHALL have port rd_addr, output, ADDR_W, meaning the read address driven to the CAM addr_in.
REQ-011 SHALL have port out_valid, output, 1, meaning the out_addr/out_data pair is valid.
REQ-012 SHALL have port out_ready, input, 1, meaning the consumer accepts the pair.
REQ-013 SHALL have port out_addr, output, ADDR_W, meaning the index of the matched cell.
REQ-014 SHALL have port out_data, output, WORD_SIZE, meaning the word read from that cell.
REQ-015 SHALL have port busy, output, 1, meaning the state is not IDLE.
REQ-016 SHALL have port done, output, 1, meaning a one-cycle pulse at scan end.
REQ-017 SHALL have port match_count, output, ADDR_W, meaning the number of pairs accepted in the last scan.

Function
REQ-018 SHALL implement the states IDLE, SCAN, EMIT and DONE.
REQ-019 IDLE & start: SHALL latch tags into the snapshot register, clear the internal counter, and go to SCAN; start SHALL be ignored outside IDLE.
REQ-020 SCAN: SHALL take idx as the lowest set bit of the snapshot through a combinational priority encoder, with the lowest index winning.
REQ-021 SCAN with snapshot == 0: SHALL go to DONE without asserting out_valid.
REQ-022 SCAN with snapshot != 0: SHALL drive rd_addr = idx combinationally and, on the edge, register out_addr = idx and out_data = cam_doutb, set out_valid, clear snapshot[idx], and go to EMIT.
REQ-023 EMIT: SHALL hold out_valid, out_addr and out_data stable until out_ready is seen.
REQ-024 EMIT on out_valid & out_ready: SHALL clear out_valid, increment the counter, and return to SCAN.
REQ-025 SHALL give a throughput of at most one pair per 2 cycles.
REQ-026 With out_ready held high, the first out_valid SHALL rise 2 cycles after the start edge.
REQ-027 DONE: SHALL assert done for exactly 1 cycle, copy the counter into match_count, and go to IDLE.
REQ-028 match_count SHALL hold its value until the next DONE.
REQ-029 abort in SCAN or EMIT: SHALL clear out_valid, clear the snapshot, and go to DONE, so match_count reports only the pairs already accepted.
REQ-030 When abort and the out_valid & out_ready handshake occur in the same cycle, the pair SHALL be counted and abort SHALL still be taken.
REQ-031 abort in IDLE or DONE SHALL have no effect.
REQ-032 Changes on tags during a scan SHALL have no effect; only the snapshot is used.
REQ-033 The counter SHALL never wrap, since at most CELL_QUANT pairs are produced and ADDR_W bits hold CELL_QUANT.
REQ-034 rd_addr SHALL be 0 in every state except SCAN.

Reset
REQ-035 rst low SHALL immediately force: state IDLE, snapshot 0, counter 0, match_count 0, out_valid 0, out_addr 0, out_data 0, done 0, busy 0.
REQ-036 Reset asserted mid-scan SHALL drop out_valid at once; no done pulse SHALL follow reset.
REQ-037 Release of reset SHALL be followed by IDLE, with the first start honoured on the first edge after release.

Verification
REQ-038 The bench SHALL cover: tags = 0x...0029 (bits 0,3,5), out_ready = 1 -> out_addr 0,3,5 on cycles 2,4,6; done on cycle 7; match_count = 3; out_data equals the CAM words at those cells.
REQ-039 The bench SHALL cover: tags all zero, start -> no out_valid; done on cycle 2; match_count = 0.
REQ-040 The bench SHALL cover: bits 1 and 2 set, out_ready low for 5 cycles -> out_addr = 1 and out_data stay stable while out_valid is held; then 2 is emitted; match_count = 2.
REQ-041 The bench SHALL cover: all 512 tags set, out_ready = 1 -> addresses 0..511 in order; match_count = 512; done 1025 cycles after start.
REQ-042 The bench SHALL cover: 4 tags set, abort on the cycle the 2nd pair handshakes -> 2 pairs emitted; done next cycle; match_count = 2.
REQ-043 The bench SHALL cover: rst pulled low while EMIT is holding out_valid -> out_valid and busy drop asynchronously; no done pulse; a new start after release scans the newly latched tags.
